uart_rx: RTL

- Asynchronous serial receiver: 8N1 by default, LSB first, fixed baud set by a clock-divide parameter.
- Recovers bytes from the rx line using a two-flop synchronizer on the input, a bit-period counter and a SIPO shift register.
- Presents each received word on a valid/ready interface to the downstream consumer. Sits at the receive pin of the UART block, mirroring the transmit path.

---
 rtl/uart_rx.sv | 109 ++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: serial receiver (start, DATA_BITS LSB first, stop) with a valid/ready word output.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_error,
`endif
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
    logic par_bad;
`else
    localparam state_t AFTER_DATA = STOP;
    localparam logic par_bad = 1'b0;
`endif

    state_t state;
    logic rx_meta, rx_s;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [DATA_BITS-1:0] sh;

    assign busy = state != IDLE;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            {rx_s, rx_meta} <= 2'b11;
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            sh <= '0;
            data_out <= '0;
            data_valid <= 1'b0;
            framing_error <= 1'b0;
            overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
            parity_error <= 1'b0;
`endif
        end else begin
            {rx_s, rx_meta} <= {rx_meta, rx_in};
            framing_error <= 1'b0;
            overrun <= 1'b0;
            if (data_valid && data_ready) data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: if (cnt == MID) begin
                    cnt <= '0;
                    idx <= '0;
                    state <= rx_s ? IDLE : DATA;
                end else cnt <= cnt + 1'b1;
                DATA: if (cnt == LAST) begin
                    cnt <= '0;
                    sh <= {rx_s, sh[DATA_BITS-1:1]};
                    idx <= idx + 1'b1;
                    if (idx == IDX_LAST) state <= AFTER_DATA;
                end else cnt <= cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                PARITY: if (cnt == LAST) begin
                    cnt <= '0;
                    par_bad <= ^{sh, rx_s};
                    state <= STOP;
                end else cnt <= cnt + 1'b1;
`endif
                STOP: if (cnt == LAST) begin
                    cnt <= '0;
                    if (!rx_s) begin
                        framing_error <= 1'b1;
                        state <= WAIT_HIGH;
                    end else begin
                        state <= IDLE;
                        // A word arriving while the previous one is being consumed still loads.
                        if (!par_bad && (!data_valid || data_ready)) begin
                            data_out <= sh;
                            data_valid <= 1'b1;
                        end else if (!par_bad) overrun <= 1'b1;
                    end
                end else cnt <= cnt + 1'b1;
                WAIT_HIGH: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
`ifdef UART_RX_PARITY_EN
            parity_error <= state == STOP && cnt == LAST && rx_s && par_bad;
`endif
        end
    end
endmodule
